// File: rtl/que_slot_arbiter.sv
// Steers one ingress byte stream into SLOT_COUNT packet queue slots and drains
// completed slots round-robin to one egress stream. Define QUE_SLOT_ARBITER_STATS_EN for packet counters.
module que_slot_arbiter #(
  parameter int SLOT_COUNT = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_data_enable,
  input  logic                    rx_good_packet,
  input  logic                    rx_bad_packet,
  output logic [7:0]              slot_data,
  output logic [SLOT_COUNT-1:0]   slot_data_enable,
  output logic [SLOT_COUNT-1:0]   slot_good_packet,
  output logic [SLOT_COUNT-1:0]   slot_bad_packet,
  input  logic [SLOT_COUNT-1:0]   slot_ready,
  input  logic [SLOT_COUNT-1:0]   slot_data_ready,
  input  logic [8*SLOT_COUNT-1:0] slot_push_data,
  input  logic [SLOT_COUNT-1:0]   slot_push_data_valid,
  output logic [SLOT_COUNT-1:0]   slot_push_data_enable,
  output logic [7:0]              tx_data,
  output logic                    tx_data_valid,
  input  logic                    tx_ready,
  output logic                    tx_busy,
  output logic                    dropped_packet
`ifdef QUE_SLOT_ARBITER_STATS_EN
  ,
  output logic [15:0]             rx_packet_count,
  output logic [15:0]             drop_count,
  output logic [15:0]             tx_packet_count
`endif
);

  localparam int IW = $clog2(SLOT_COUNT);

  typedef enum logic [1:0] {I_IDLE, I_STEER, I_DROP} ing_e;
  typedef enum logic [1:0] {E_IDLE, E_DRAIN, E_GAP} egr_e;

  ing_e                  ist_q, ist_d;
  egr_e                  est_q, est_d;
  logic [IW-1:0]         islot_q, islot_d;
  logic [IW-1:0]         grant_q, grant_d;
  logic [IW-1:0]         rr_q, rr_d;
  logic [IW-1:0]         sticky_q, sticky_d;
  logic                  sticky_vld_q, sticky_vld_d;
  logic [SLOT_COUNT-1:0] reserved_q, reserved_d;

  logic [SLOT_COUNT-1:0] res_set, res_clr, sticky_mask, cand;
  logic [SLOT_COUNT-1:0] den_c, good_c, bad_c, pen_c;
  logic [IW-1:0]         sel, g_sel;
  logic                  sel_ok, g_ok, drop_c, tx_done;
  logic [7:0]            txd_c;
  logic                  txv_c;
  logic [7:0]            push_arr [SLOT_COUNT];

  for (genvar s = 0; s < SLOT_COUNT; s++) begin : g_unpack
    assign push_arr[s]    = slot_push_data[8*s +: 8];
    assign sticky_mask[s] = sticky_vld_q && (sticky_q == IW'(s));
  end

  // Ingress: pick a slot at packet start, then steer every strobe to it.
  always_comb begin
    ist_d        = ist_q;
    islot_d      = islot_q;
    sticky_d     = sticky_q;
    sticky_vld_d = sticky_vld_q;
    res_set      = '0;
    den_c        = '0;
    good_c       = '0;
    bad_c        = '0;
    drop_c       = 1'b0;
    sel_ok       = 1'b0;
    sel          = '0;
    if (sticky_vld_q) begin
      sel_ok = 1'b1;
      sel    = sticky_q;
    end else begin
      for (int i = SLOT_COUNT-1; i >= 0; i--)
        if (slot_ready[i] && !reserved_q[i]) begin
          sel_ok = 1'b1;
          sel    = IW'(i);
        end
    end
    case (ist_q)
      I_IDLE: if (rx_data_enable) begin
        if (sel_ok) begin
          res_set[sel] = 1'b1;
          den_c[sel]   = 1'b1;
          islot_d      = sel;
          ist_d        = I_STEER;
        end else begin
          drop_c = 1'b1;
          ist_d  = I_DROP;
        end
      end
      I_STEER: begin
        den_c[islot_q]  = rx_data_enable;
        good_c[islot_q] = rx_good_packet;
        bad_c[islot_q]  = rx_bad_packet;
        // A bad packet pins the slot so the next packet overwrites its flushed FIFO.
        if (rx_bad_packet) begin
          sticky_vld_d = 1'b1;
          sticky_d     = islot_q;
          ist_d        = I_IDLE;
        end else if (rx_good_packet) begin
          sticky_vld_d = 1'b0;
          ist_d        = I_IDLE;
        end
      end
      I_DROP: if (rx_good_packet || rx_bad_packet) ist_d = I_IDLE;
      default: ist_d = I_IDLE;
    endcase
  end

  // Egress: round-robin grant, hold until the slot drops data_ready, then one gap cycle.
  always_comb begin
    est_d   = est_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    res_clr = '0;
    pen_c   = '0;
    txd_c   = '0;
    txv_c   = 1'b0;
    tx_done = 1'b0;
    g_ok    = 1'b0;
    g_sel   = '0;
    cand    = slot_data_ready & reserved_q & ~sticky_mask;
    for (int k = 0; k < SLOT_COUNT; k++) begin
      int j;
      j = (int'(rr_q) + k) % SLOT_COUNT;
      if (!g_ok && cand[j]) begin
        g_ok  = 1'b1;
        g_sel = IW'(j);
      end
    end
    case (est_q)
      E_IDLE: if (g_ok) begin
        grant_d = g_sel;
        est_d   = E_DRAIN;
      end
      E_DRAIN: begin
        txd_c          = push_arr[grant_q];
        txv_c          = slot_push_data_valid[grant_q];
        pen_c[grant_q] = tx_ready && slot_push_data_valid[grant_q];
        if (!slot_data_ready[grant_q]) begin
          res_clr[grant_q] = 1'b1;
          rr_d    = (grant_q == IW'(SLOT_COUNT-1)) ? '0 : grant_q + 1'b1;
          est_d   = E_GAP;
          tx_done = 1'b1;
        end
      end
      E_GAP:   est_d = E_IDLE;
      default: est_d = E_IDLE;
    endcase
    reserved_d = (reserved_q | res_set) & ~res_clr;
  end

  // Outputs are forced low during reset even though some are combinational.
  always_comb begin
    slot_data             = reset ? '0 : rx_data;
    slot_data_enable      = reset ? '0 : den_c;
    slot_good_packet      = reset ? '0 : good_c;
    slot_bad_packet       = reset ? '0 : bad_c;
    dropped_packet        = !reset && drop_c;
    slot_push_data_enable = reset ? '0 : pen_c;
    tx_data               = reset ? '0 : txd_c;
    tx_data_valid         = !reset && txv_c;
    tx_busy               = !reset && (est_q == E_DRAIN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ist_q        <= I_IDLE;
      est_q        <= E_IDLE;
      islot_q      <= '0;
      grant_q      <= '0;
      rr_q         <= '0;
      sticky_q     <= '0;
      sticky_vld_q <= 1'b0;
      reserved_q   <= '0;
    end else begin
      ist_q        <= ist_d;
      est_q        <= est_d;
      islot_q      <= islot_d;
      grant_q      <= grant_d;
      rr_q         <= rr_d;
      sticky_q     <= sticky_d;
      sticky_vld_q <= sticky_vld_d;
      reserved_q   <= reserved_d;
    end
  end

`ifdef QUE_SLOT_ARBITER_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_packet_count <= '0;
      drop_count      <= '0;
      tx_packet_count <= '0;
    end else begin
      if (ist_q == I_STEER && rx_good_packet && !rx_bad_packet && rx_packet_count != 16'hFFFF)
        rx_packet_count <= rx_packet_count + 16'd1;
      if (drop_c && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
      if (tx_done && tx_packet_count != 16'hFFFF)
        tx_packet_count <= tx_packet_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_que_slot_arbiter.sv
// Scoreboard bench for que_slot_arbiter: behavioural slot FIFOs, directed packets,
// separate ingress/egress monitors popping expected events.
module tb_que_slot_arbiter;
  localparam int N = 4;

  typedef struct {
    int         kind;   // 0 write, 1 good, 2 bad, 3 drop
    int         slot;
    logic [7:0] data;
  } ev_t;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [7:0]     rx_data = '0;
  logic           rx_data_enable = 1'b0, rx_good_packet = 1'b0, rx_bad_packet = 1'b0;
  logic [7:0]     slot_data;
  logic [N-1:0]   slot_data_enable, slot_good_packet, slot_bad_packet;
  logic [N-1:0]   slot_ready, slot_data_ready, slot_push_data_valid, slot_push_data_enable;
  logic [8*N-1:0] slot_push_data;
  logic [7:0]     tx_data;
  logic           tx_data_valid, tx_busy, dropped_packet;
  logic           tx_ready = 1'b0;
`ifdef QUE_SLOT_ARBITER_STATS_EN
  logic [15:0]    rx_packet_count, drop_count, tx_packet_count;
`endif

  que_slot_arbiter #(.SLOT_COUNT(N)) dut (
    .clock(clock), .reset(reset),
    .rx_data(rx_data), .rx_data_enable(rx_data_enable),
    .rx_good_packet(rx_good_packet), .rx_bad_packet(rx_bad_packet),
    .slot_data(slot_data), .slot_data_enable(slot_data_enable),
    .slot_good_packet(slot_good_packet), .slot_bad_packet(slot_bad_packet),
    .slot_ready(slot_ready), .slot_data_ready(slot_data_ready),
    .slot_push_data(slot_push_data), .slot_push_data_valid(slot_push_data_valid),
    .slot_push_data_enable(slot_push_data_enable),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_ready(tx_ready),
    .tx_busy(tx_busy), .dropped_packet(dropped_packet)
`ifdef QUE_SLOT_ARBITER_STATS_EN
    , .rx_packet_count(rx_packet_count), .drop_count(drop_count),
    .tx_packet_count(tx_packet_count)
`endif
  );

  always #5 clock = ~clock;

  // Slot model: FIFO fills on writes, completes on good, flushes on bad,
  // and drops data_ready once the last byte is read.
  logic [7:0] mem [N][64];
  logic [5:0] wp [N];
  logic [5:0] rp [N];
  logic [N-1:0] done, hold = '0, nrdy = '0;

  for (genvar s = 0; s < N; s++) begin : g_slot
    assign slot_ready[s]           = !done[s] && !nrdy[s];
    assign slot_data_ready[s]      = done[s] && !hold[s];
    assign slot_push_data_valid[s] = done[s] && (wp[s] != rp[s]);
    assign slot_push_data[8*s +: 8] = mem[s][rp[s]];
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        wp[i] <= '0;
        rp[i] <= '0;
      end
      done <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (slot_data_enable[i]) begin
          mem[i][wp[i]] <= slot_data;
          wp[i] <= wp[i] + 6'd1;
        end
        if (slot_bad_packet[i]) begin
          wp[i] <= '0;
          rp[i] <= '0;
          done[i] <= 1'b0;
        end else if (slot_good_packet[i]) begin
          done[i] <= 1'b1;
        end else if (slot_push_data_enable[i]) begin
          if (wp[i] - rp[i] == 6'd1) begin
            done[i] <= 1'b0;
            wp[i] <= '0;
            rp[i] <= '0;
          end else begin
            rp[i] <= rp[i] + 6'd1;
          end
        end
      end
    end
  end

  int  tests = 0, fails = 0;
  int  cyc = 0;
  ev_t exp_rx[$];
  ev_t exp_tx[$];
  int  first_cyc[N], last_cyc[N];
  int  prev_slot = -1;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic chk_ing(input int kind, input int slot, input logic [7:0] d);
    ev_t e;
    tests++;
    if (exp_rx.size() == 0) begin
      fails++;
      $display("FAIL ingress unexpected: kind %0d slot %0d data %0h, none expected", kind, slot, d);
    end else begin
      e = exp_rx.pop_front();
      if (e.kind != kind || e.slot != slot || e.data !== d) begin
        fails++;
        $display("FAIL ingress: got kind %0d slot %0d data %0h expected kind %0d slot %0d data %0h",
                 kind, slot, d, e.kind, e.slot, e.data);
      end
    end
  endtask

  // Ingress monitor
  always @(negedge clock) begin
    if (!reset) begin
      if (dropped_packet) chk_ing(3, 0, 8'h00);
      for (int i = 0; i < N; i++) begin
        if (slot_data_enable[i]) chk_ing(0, i, slot_data);
        if (slot_good_packet[i]) chk_ing(1, i, 8'h00);
        if (slot_bad_packet[i])  chk_ing(2, i, 8'h00);
      end
    end
  end

  // Egress monitor
  always @(negedge clock) begin
    ev_t e;
    logic [N-1:0] m;
    if (!reset) begin
      if (tx_data_valid && tx_ready) begin
        tests++;
        if (exp_tx.size() == 0) begin
          fails++;
          $display("FAIL egress unexpected: byte %0h en %b, none expected", tx_data, slot_push_data_enable);
        end else begin
          e = exp_tx.pop_front();
          m = '0;
          m[e.slot] = 1'b1;
          if (tx_data !== e.data || slot_push_data_enable !== m) begin
            fails++;
            $display("FAIL egress: got byte %0h en %b expected byte %0h en %b",
                     tx_data, slot_push_data_enable, e.data, m);
          end
          if (e.slot != prev_slot) first_cyc[e.slot] = cyc;
          last_cyc[e.slot] = cyc;
          prev_slot = e.slot;
        end
      end else if (slot_push_data_enable != '0) begin
        tests++;
        fails++;
        $display("FAIL egress strobe: en %b with tx_ready %b valid %b", slot_push_data_enable, tx_ready, tx_data_valid);
      end
    end
  end

  task automatic exp_tx_pkt(input int slot, input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) exp_tx.push_back('{0, slot, 8'(int'(base) + k)});
  endtask

  // slot < 0 means the packet is expected to be dropped.
  task automatic send_pkt(input int slot, input logic [7:0] base, input int n, input bit good);
    if (slot < 0) exp_rx.push_back('{3, 0, 8'h00});
    else begin
      for (int k = 0; k < n; k++) exp_rx.push_back('{0, slot, 8'(int'(base) + k)});
      exp_rx.push_back('{good ? 1 : 2, slot, 8'h00});
    end
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
      rx_data_enable = 1'b1;
      rx_data = 8'(int'(base) + k);
    end
    @(posedge clock); #1;
    rx_data_enable = 1'b0;
    rx_good_packet = good;
    rx_bad_packet  = !good;
    @(posedge clock); #1;
    rx_good_packet = 1'b0;
    rx_bad_packet  = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while ((exp_rx.size() != 0 || exp_tx.size() != 0) && c < budget) begin
      @(posedge clock);
      c++;
    end
    tests++;
    if (c >= budget) begin
      fails++;
      $display("FAIL %s timeout: %0d rx / %0d tx events outstanding, required 0", name, exp_rx.size(), exp_tx.size());
    end
    repeat (5) @(posedge clock);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset with live ingress to prove outputs are forced low.
    rx_data = 8'h5A;
    rx_data_enable = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset slot_data", 32'(slot_data), 32'h0);
    chk("reset slot_data_enable", 32'(slot_data_enable), 32'h0);
    chk("reset tx_valid/busy/drop", {29'h0, tx_data_valid, tx_busy, dropped_packet}, 32'h0);
    chk("reset push_enable", 32'(slot_push_data_enable), 32'h0);
    rx_data_enable = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;

    // Single 10-byte packet through slot 0
    tx_ready = 1'b1;
    exp_tx_pkt(0, 8'h01, 10);
    send_pkt(0, 8'h01, 10, 1'b1);
    wait_drain("single", 300);

    // Four packets with egress stalled fill all slots; a fifth is dropped
    tx_ready = 1'b0;
    for (int p = 0; p < N; p++) begin
      exp_tx_pkt(p, 8'(8'h10 + 16*p), 3);
      send_pkt(p, 8'(8'h10 + 16*p), 3, 1'b1);
    end
    send_pkt(-1, 8'hE0, 3, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    tx_ready = 1'b1;
    wait_drain("fill/drop", 400);

    // Round robin: move rr to 2, then slots 1 and 3 ready together
    hold = '1;
    send_pkt(0, 8'h40, 3, 1'b1);
    send_pkt(1, 8'h50, 3, 1'b1);
    send_pkt(2, 8'h60, 3, 1'b1);
    send_pkt(3, 8'h70, 3, 1'b1);
    exp_tx_pkt(1, 8'h50, 3);
    hold[1] = 1'b0;
    wait_drain("rr setup", 300);
    hold[1] = 1'b1;
    send_pkt(1, 8'h80, 3, 1'b1);
    exp_tx_pkt(3, 8'h70, 3);
    exp_tx_pkt(1, 8'h80, 3);
    hold = 4'b0101;
    wait_drain("rr 3-then-1", 300);
    // last byte, data_ready drop seen, E_GAP, arbitration, first byte
    chk("rr gap cycles", 32'(first_cyc[1] - last_cyc[3]), 32'd4);
    exp_tx_pkt(2, 8'h60, 3);
    exp_tx_pkt(0, 8'h40, 3);
    hold = '0;
    wait_drain("rr 2-then-0", 300);

    // Bad packet pins slot 0 for the next packet even though it is not ready
    send_pkt(0, 8'h90, 2, 1'b0);
    nrdy[0] = 1'b1;
    exp_tx_pkt(0, 8'hA0, 3);
    send_pkt(0, 8'hA0, 3, 1'b1);
    wait_drain("sticky", 300);
    nrdy[0] = 1'b0;

    // tx_ready toggling during a drain
    tx_ready = 1'b0;
    exp_tx_pkt(0, 8'hB0, 4);
    send_pkt(0, 8'hB0, 4, 1'b1);
    repeat (2) @(posedge clock);
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
      tx_ready = (k % 2 == 0);
    end
    tx_ready = 1'b1;
    wait_drain("toggle", 300);

    // Reset mid-drain (slot 0 held) and mid-steer (slot 1 filling)
    tx_ready = 1'b0;
    exp_tx_pkt(0, 8'hC0, 3);
    send_pkt(0, 8'hC0, 3, 1'b1);
`ifdef QUE_SLOT_ARBITER_STATS_EN
    chk("rx_packet_count", 32'(rx_packet_count), 32'd13);
    chk("drop_count", 32'(drop_count), 32'd1);
    chk("tx_packet_count", 32'(tx_packet_count), 32'd12);
`endif
    exp_rx.push_back('{0, 1, 8'hD0});
    exp_rx.push_back('{0, 1, 8'hD1});
    @(posedge clock); #1;
    rx_data_enable = 1'b1;
    rx_data = 8'hD0;
    @(posedge clock); #1;
    rx_data = 8'hD1;
    @(posedge clock); #1;
    chk("mid-drain busy before reset", 32'(tx_busy), 32'h1);
    rx_data = 8'hD2;
    tx_ready = 1'b1;
    reset = 1'b1;
    #1;
    exp_tx.delete();
    chk("midrst slot_data_enable", 32'(slot_data_enable), 32'h0);
    chk("midrst slot_data", 32'(slot_data), 32'h0);
    chk("midrst tx_data/valid", {23'h0, tx_data, tx_data_valid}, 32'h0);
    chk("midrst busy/drop", {30'h0, tx_busy, dropped_packet}, 32'h0);
    chk("midrst push_enable", 32'(slot_push_data_enable), 32'h0);
    chk("midrst good/bad", {24'h0, slot_good_packet, slot_bad_packet}, 32'h0);
`ifdef QUE_SLOT_ARBITER_STATS_EN
    chk("midrst counters", 32'(rx_packet_count | drop_count | tx_packet_count), 32'h0);
`endif
    @(posedge clock); #1;
    rx_data_enable = 1'b0;
    reset = 1'b0;
    exp_tx_pkt(0, 8'hE0, 2);
    send_pkt(0, 8'hE0, 2, 1'b1);
    wait_drain("post reset", 300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
